lfsr_draw_engine: RTL and testbench

LFSR_DRAW_ENGINE -- requirements
Module: lfsr_draw_engine

---
 rtl/lfsr_draw_engine.sv | 74 +++++++
 tb/tb_lfsr_draw_engine.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_draw_engine.sv
// lfsr_draw_engine: Galois-LFSR number draw engine presenting DRAW_CNT numbers over a valid/ready handshake.
// Define NO_REPEAT_EN to exclude numbers already accepted in the current draw.
module lfsr_draw_engine #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] SEED     = 8'h89,
   parameter logic [WIDTH-1:0] TAPS     = 8'hF3,
   parameter int               MIN_VAL  = 1,
   parameter int               MAX_VAL  = 73,
   parameter int               DRAW_CNT = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         seed_load,
   input  logic [WIDTH-1:0]             seed_in,
   input  logic                         num_ready,
   output logic [WIDTH-1:0]             num_out,
   output logic                         num_valid,
   output logic [$clog2(DRAW_CNT+1)-1:0] draw_idx,
   output logic                         busy,
   output logic                         done,
   output logic [WIDTH-1:0]             lfsr_state
);
   localparam int NUM = MAX_VAL - MIN_VAL + 1;
   localparam int DW  = $clog2(DRAW_CNT + 1);
   typedef enum logic [1:0] {IDLE, SEARCH, PRESENT, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] lfsr;
   logic in_range, hit, hs, last;
   assign lfsr_state = lfsr;
   assign busy       = state != IDLE;
   assign num_valid  = state == PRESENT;
   assign done       = state == DONE;
   assign in_range   = lfsr >= WIDTH'(MIN_VAL) && lfsr <= WIDTH'(MAX_VAL);
   assign hs         = num_valid && num_ready && !abort;
   assign last       = draw_idx == DW'(DRAW_CNT - 1);
   // Bit 0 of TAPS is ignored: the feedback bit always re-enters at position 0.
   always_ff @(posedge clk)
      if (rst) lfsr <= SEED;
      else if (seed_load) lfsr <= seed_in == '0 ? SEED : seed_in;
      else lfsr <= {lfsr[WIDTH-2:0], lfsr[WIDTH-1]} ^ ({WIDTH{lfsr[WIDTH-1]}} & {TAPS[WIDTH-1:1], 1'b0});
`ifdef NO_REPEAT_EN
   localparam int IW = NUM > 1 ? $clog2(NUM) : 1;
   logic [NUM-1:0] used;
   assign hit = in_range && !used[IW'(lfsr - WIDTH'(MIN_VAL))];
   always_ff @(posedge clk)
      if (rst || (state == IDLE && start)) used <= '0;
      else if (hs) used[IW'(num_out - WIDTH'(MIN_VAL))] <= 1'b1;
`else
   assign hit = in_range;
`endif
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? SEARCH : IDLE;
         SEARCH:  state_nxt = abort ? IDLE : hit ? PRESENT : SEARCH;
         PRESENT: state_nxt = abort ? IDLE : !num_ready ? PRESENT : last ? DONE : SEARCH;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         num_out  <= '0;
         draw_idx <= '0;
      end else begin
         if (state == IDLE && start) draw_idx <= '0;
         if (state == SEARCH && hit) num_out <= lfsr;
         if (hs) draw_idx <= draw_idx + 1'b1;
      end
endmodule

// File: tb/tb_lfsr_draw_engine.sv
// tb_lfsr_draw_engine: randomized draws checked against an arithmetic LFSR model and a list of drawn numbers.
module tb_lfsr_draw_engine;
   localparam int           W    = 8;
   localparam logic [W-1:0] SEED = 8'h89;
   localparam logic [W-1:0] TAPS = 8'hF3;
   localparam int           MINV = 1;
   localparam int           MAXV = 73;
   localparam int           DC   = 6;
   localparam int           DW   = $clog2(DC + 1);
   logic clk = 1'b0;
   logic rst, start, abort, seed_load, num_ready;
   logic [W-1:0] seed_in, num_out, lfsr_state;
   logic [DW-1:0] draw_idx;
   logic num_valid, busy, done;
   int checks = 0, errors = 0;
   int m;
   int drawn[$];

   lfsr_draw_engine #(.WIDTH(W), .SEED(SEED), .TAPS(TAPS), .MIN_VAL(MINV), .MAX_VAL(MAXV), .DRAW_CNT(DC)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .seed_load(seed_load), .seed_in(seed_in),
      .num_ready(num_ready), .num_out(num_out), .num_valid(num_valid), .draw_idx(draw_idx),
      .busy(busy), .done(done), .lfsr_state(lfsr_state));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Multiplication by x modulo the tap polynomial, written as plain integer arithmetic.
   function automatic int adv(input int r);
      int n;
      n = (r * 2) % (1 << W);
      if (r >= (1 << (W - 1))) n = n ^ ((int'(TAPS) & ~1) | 1);
      return n;
   endfunction

   function automatic bit hit(input int v);
      if (v < MINV || v > MAXV) return 1'b0;
`ifdef NO_REPEAT_EN
      foreach (drawn[i]) if (drawn[i] == v) return 1'b0;
`endif
      return 1'b1;
   endfunction

   task automatic tick();
      logic r, sl;
      int si;
      r = rst;
      sl = seed_load;
      si = int'(seed_in);
      @(posedge clk);
      #1;
      m = r ? int'(SEED) : sl ? (si == 0 ? int'(SEED) : si) : adv(m);
      check("lfsr", lfsr_state, m);
   endtask

   task automatic draw(input int wmin, input int wmax, input int abort_k, input int rst_k);
      int exp, n, dup;
      drawn.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_start", busy, 1);
      check("idx_start", draw_idx, 0);
      check("valid_start", num_valid, 0);
      for (int k = 0; k < DC; k++) begin
         n = 0;
         while (!hit(m) && n < 5000) begin
            num_ready = 1'($urandom_range(1, 0));
            tick();
            n++;
         end
         if (n >= 5000) begin
            check("search_timeout", 1, 0);
            return;
         end
         exp = m;
         tick();
         check("valid", num_valid, 1);
         check("num_out", num_out, exp);
         n = $urandom_range(wmax, wmin);
         num_ready = 1'b0;
         for (int i = 0; i < n; i++) begin
            start = 1'($urandom_range(1, 0));
            tick();
            check("hold_valid", num_valid, 1);
            check("hold_out", num_out, exp);
            check("hold_idx", draw_idx, k);
         end
         start = 1'b0;
         if (k == rst_k) begin
            rst = 1'b1;
            tick();
            check("rst_out", num_out, 0);
            check("rst_valid", num_valid, 0);
            check("rst_idx", draw_idx, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            rst = 1'b0;
            return;
         end
         if (k == abort_k) begin
            abort = 1'b1;
            num_ready = 1'b1;
            tick();
            abort = 1'b0;
            num_ready = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_valid", num_valid, 0);
            check("abort_idx", draw_idx, k);
            check("abort_done", done, 0);
            tick();
            check("abort_nodone", done, 0);
            return;
         end
         check("range", num_out >= W'(MINV) && num_out <= W'(MAXV), 1);
`ifdef NO_REPEAT_EN
         dup = 0;
         foreach (drawn[i]) if (drawn[i] == int'(num_out)) dup++;
         check("distinct", dup, 0);
`endif
         num_ready = 1'b1;
         tick();
         drawn.push_back(exp);
         check("hs_idx", draw_idx, k + 1);
         check("hs_valid", num_valid, 0);
         check("hs_done", done, k == DC - 1);
         if (k == DC - 1) begin
            tick();
            check("done_once", done, 0);
            check("end_busy", busy, 0);
            check("end_idx", draw_idx, DC);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; seed_load = 1'b0; seed_in = '0; num_ready = 1'b0;
      tick();
      tick();
      check("rst_lfsr", lfsr_state, 8'h89);
      check("rst_valid0", num_valid, 0);
      check("rst_busy0", busy, 0);
      check("rst_done0", done, 0);
      check("rst_idx0", draw_idx, 0);
      check("rst_out0", num_out, 0);
      rst = 1'b0;
      tick();
      check("lfsr_e1", lfsr_state, 8'hE1);
      seed_load = 1'b1;
      tick();
      check("seed_zero", lfsr_state, 8'h89);
      seed_in = 8'h05;
      tick();
      check("seed_05", lfsr_state, 8'h05);
      check("seed_busy", busy, 0);
      for (int i = 0; i < 5; i++) begin
         seed_in = W'($urandom);
         tick();
      end
      seed_load = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      draw(0, 0, -1, -1);
      draw(20, 20, -1, -1);
      draw(0, 3, 2, -1);
      draw(0, 3, -1, 3);
      draw(0, 3, -1, -1);
      for (int d = 0; d < 4; d++) begin
         for (int i = $urandom_range(7, 0); i > 0; i--) tick();
         draw(0, 4, -1, -1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end
endmodule
